// File: rtl/rv_pipe_ctrl.sv
// rv_pipe_ctrl: control and hazard core for an in-order RISC-V integer pipeline.
//
// Owns the fetch PC and a per-stage valid/metadata shift chain
// (0=IF, 1=ID, 2=EX, 3..STAGES-2=MEM, STAGES-1=WB). It detects load-use
// hazards against the instruction in ID and computes forwarding selects for
// the instruction in EX. It also applies taken-branch redirects. Datapath
// registers and the register file live outside this block.
//
// Fetch handshake: the instruction memory raises imem_ready when it can
// deliver an instruction this cycle. The instruction is accepted into ID on
// the edge where fetch_fire (= imem_ready & !stall & !flush) is high. The PC
// advances only on that edge.
//
// Ports:
//   clk, reset                 clock; asynchronous active-high reset
//   imem_ready                 instruction memory can deliver this cycle
//   id_rs1/rs2/rd, id_use_*    ID-stage register fields and read enables
//   id_reg_write, id_is_load   ID-stage instruction class
//   ex_br_taken, ex_br_target  taken branch/jump in EX and its target
//   pc                         current fetch address
//   fetch_fire                 instruction accepted into ID this edge
//   stall                      load-use stall (PC and ID hold, bubble into EX)
//   flush                      redirect: kills ID and the next fetch
//   stage_valid                bit0 = fetch_fire, bit i>0 = stage i valid
//   ex_fwd_rs1/rs2             0 = regfile, k = forward from stage k
//   id_wb_byp_rs1/rs2          WB result must bypass the regfile read in ID
//   retire, retire_count       valid instruction in WB; wrapping retire count
module rv_pipe_ctrl #(
    parameter int              XLEN     = 32,
    parameter int              STAGES   = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             SELW     = $clog2(STAGES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              imem_ready,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    input  logic [XLEN-1:0]   ex_br_target,
    output logic [XLEN-1:0]   pc,
    output logic              fetch_fire,
    output logic              stall,
    output logic              flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [SELW-1:0]   ex_fwd_rs1,
    output logic [SELW-1:0]   ex_fwd_rs2,
    output logic              id_wb_byp_rs1,
    output logic              id_wb_byp_rs2,
    output logic              retire,
    output logic [31:0]       retire_count
);

    localparam int WB = STAGES - 1;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use_rs1;
        logic       use_rs2;
        logic       reg_write;
        logic       is_load;
    } meta_t;

    logic [XLEN-1:0]   pc_q;
    logic [STAGES-1:1] v_q;
    meta_t             meta_q [2:STAGES-1];
    logic [31:0]       retire_cnt_q;
    meta_t             id_meta;
    logic              lu_hit;

    always_comb begin
        id_meta           = '0;
        id_meta.rd        = id_rd;
        id_meta.rs1       = id_rs1;
        id_meta.rs2       = id_rs2;
        id_meta.use_rs1   = id_use_rs1;
        id_meta.use_rs2   = id_use_rs2;
        id_meta.reg_write = id_reg_write;
        id_meta.is_load   = id_is_load;
    end

    // A load still in EX..STAGES-3 has not produced its data by the time the
    // consumer would reach EX. Loads in the last MEM stage or in WB are
    // covered by forwarding instead.
    always_comb begin
        lu_hit = 1'b0;
        for (int k = 2; k <= STAGES - 3; k++) begin
            if (v_q[k] && meta_q[k].is_load && (meta_q[k].rd != 5'd0) &&
                ((id_use_rs1 && (meta_q[k].rd == id_rs1)) ||
                 (id_use_rs2 && (meta_q[k].rd == id_rs2))))
                lu_hit = 1'b1;
        end
    end

    assign flush      = v_q[2] & ex_br_taken;
    assign stall      = ~flush & v_q[1] & lu_hit;
    assign fetch_fire = imem_ready & ~stall & ~flush;

    // Scan from oldest to youngest so the youngest match is the last one
    // written. A load before WB has no data yet, so it is skipped.
    always_comb begin
        ex_fwd_rs1 = '0;
        ex_fwd_rs2 = '0;
        for (int k = STAGES - 1; k >= 3; k--) begin
            if (v_q[k] && meta_q[k].reg_write &&
                ((k == STAGES - 1) || !meta_q[k].is_load)) begin
                if (meta_q[k].rd == meta_q[2].rs1) ex_fwd_rs1 = SELW'(k);
                if (meta_q[k].rd == meta_q[2].rs2) ex_fwd_rs2 = SELW'(k);
            end
        end
        if (!(v_q[2] && meta_q[2].use_rs1 && (meta_q[2].rs1 != 5'd0))) ex_fwd_rs1 = '0;
        if (!(v_q[2] && meta_q[2].use_rs2 && (meta_q[2].rs2 != 5'd0))) ex_fwd_rs2 = '0;
    end

    assign id_wb_byp_rs1 = v_q[1] & id_use_rs1 & (id_rs1 != 5'd0) & v_q[WB] &
                           meta_q[WB].reg_write & (meta_q[WB].rd == id_rs1);
    assign id_wb_byp_rs2 = v_q[1] & id_use_rs2 & (id_rs2 != 5'd0) & v_q[WB] &
                           meta_q[WB].reg_write & (meta_q[WB].rd == id_rs2);

    assign pc           = pc_q;
    assign stage_valid  = {v_q, fetch_fire};
    assign retire       = v_q[WB];
    assign retire_count = retire_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            v_q          <= '0;
            retire_cnt_q <= '0;
            for (int i = 2; i <= STAGES - 1; i++) meta_q[i] <= '0;
        end else begin
            if (retire) retire_cnt_q <= retire_cnt_q + 32'd1;

            // Stages past EX always advance; stalls and flushes only act on IF..EX.
            for (int i = 3; i <= STAGES - 1; i++) begin
                v_q[i]    <= v_q[i-1];
                meta_q[i] <= meta_q[i-1];
            end
            // Stage 2 metadata is loaded every edge; v_q[2] decides whether it counts.
            meta_q[2] <= id_meta;

            if (flush) begin
                pc_q   <= ex_br_target;
                v_q[1] <= 1'b0;
                v_q[2] <= 1'b0;
            end else if (stall) begin
                v_q[2] <= 1'b0;
            end else begin
                if (fetch_fire) pc_q <= pc_q + XLEN'(4);
                v_q[1] <= fetch_fire;
                v_q[2] <= v_q[1];
            end
        end
    end

endmodule

// File: tb/tb_rv_pipe_ctrl.sv
// Testbench for rv_pipe_ctrl: a 5-stage and a 7-stage instance share one
// stimulus set; each scenario task checks the instance it targets.
module tb_rv_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;

    logic [31:0] pc5, count5;
    logic        fetch_fire5, stall5, flush5, byp1_5, byp2_5, retire5;
    logic [4:0]  sv5;
    logic [2:0]  fwd1_5, fwd2_5;

    logic [31:0] pc7, count7;
    logic        fetch_fire7, stall7, flush7, byp1_7, byp2_7, retire7;
    logic [6:0]  sv7;
    logic [2:0]  fwd1_7, fwd2_7;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    rv_pipe_ctrl #(.XLEN(32), .STAGES(5), .RESET_PC(32'h0)) u5 (
        .clk(clk), .reset(reset), .imem_ready(imem_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .pc(pc5), .fetch_fire(fetch_fire5), .stall(stall5), .flush(flush5),
        .stage_valid(sv5), .ex_fwd_rs1(fwd1_5), .ex_fwd_rs2(fwd2_5),
        .id_wb_byp_rs1(byp1_5), .id_wb_byp_rs2(byp2_5),
        .retire(retire5), .retire_count(count5)
    );

    rv_pipe_ctrl #(.XLEN(32), .STAGES(7), .RESET_PC(32'h80)) u7 (
        .clk(clk), .reset(reset), .imem_ready(imem_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .pc(pc7), .fetch_fire(fetch_fire7), .stall(stall7), .flush(flush7),
        .stage_valid(sv7), .ex_fwd_rs1(fwd1_7), .ex_fwd_rs2(fwd2_7),
        .id_wb_byp_rs1(byp1_7), .id_wb_byp_rs2(byp2_7),
        .retire(retire7), .retire_count(count7)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic ld);
        id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_is_load = ld;
    endtask

    task automatic set_nop();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; ex_br_taken = 1'b0; ex_br_target = '0;
        set_nop();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scenarios
    task automatic test_reset();
        #2;
        tests++;
        if (pc5 !== 32'h0 || pc7 !== 32'h80) begin
            fails++; $display("FAIL reset_pc: got %h/%h want 0/80", pc5, pc7);
        end
        tests++;
        if (sv5 !== 5'b0 || sv7 !== 7'b0 || count5 !== 32'd0 || count7 !== 32'd0) begin
            fails++; $display("FAIL reset_state: sv %b/%b cnt %0d/%0d want 0", sv5, sv7, count5, count7);
        end
        tests++;
        if ({stall5, flush5, fetch_fire5, byp1_5, byp2_5, retire5, fwd1_5, fwd2_5} !== 12'b0) begin
            fails++; $display("FAIL reset_comb: got %b want 0",
                              {stall5, flush5, fetch_fire5, byp1_5, byp2_5, retire5, fwd1_5, fwd2_5});
        end
    endtask

    task automatic test_sequential();
        int first_ret;
        logic [31:0] e;
        do_reset();
        imem_ready = 1'b1;
        #1;
        tests++;
        if (fetch_fire5 !== 1'b1 || pc5 !== 32'h0) begin
            fails++; $display("FAIL seq_start: ff=%b pc=%h want 1/0", fetch_fire5, pc5);
        end
        for (int c = 1; c <= 8; c++) exp_q.push_back(32'(4 * c));
        first_ret = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            e = exp_q.pop_front();
            tests++;
            if (pc5 !== e) begin
                fails++; $display("FAIL seq_pc cycle %0d: got %h want %h", c, pc5, e);
            end
            if (retire5 === 1'b1 && first_ret == 0) first_ret = c;
        end
        tests++;
        if (first_ret != 4) begin
            fails++; $display("FAIL seq_first_retire: got cycle %0d want 4 (0 = never within 8)", first_ret);
        end
        tests++;
        if (count5 !== 32'd4) begin
            fails++; $display("FAIL seq_count: got %0d want 4", count5);
        end
        tests++;
        if (pc7 !== 32'hA0) begin
            fails++; $display("FAIL seq_pc7: got %h want a0", pc7);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        imem_ready = 1'b1;
        tick();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
        #1;
        tests++;
        if (stall5 !== 1'b0) begin
            fails++; $display("FAIL lu_nostall_first: got %b want 0", stall5);
        end
        tick();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x1
        #1;
        tests++;
        if (stall5 !== 1'b1 || fetch_fire5 !== 1'b0 || pc5 !== 32'h8) begin
            fails++; $display("FAIL lu_stall: stall=%b ff=%b pc=%h want 1/0/8", stall5, fetch_fire5, pc5);
        end
        tick();
        #1;
        tests++;
        if (stall5 !== 1'b0 || sv5 !== 5'b01011 || pc5 !== 32'h8 || fwd1_5 !== 3'd0) begin
            fails++; $display("FAIL lu_bubble: stall=%b sv=%b pc=%h fwd=%0d want 0/01011/8/0",
                              stall5, sv5, pc5, fwd1_5);
        end
        tick();
        set_nop();
        #1;
        tests++;
        if (fwd1_5 !== 3'd4 || fwd2_5 !== 3'd0 || pc5 !== 32'hC) begin
            fails++; $display("FAIL lu_fwd: fwd1=%0d fwd2=%0d pc=%h want 4/0/c", fwd1_5, fwd2_5, pc5);
        end
    endtask

    task automatic test_back_to_back();
        // expected {byp1, byp2, fwd1[2:0], fwd2[2:0]} once the listed instr is in ID
        logic [4:0]  t_rs1 [5] = '{5'd1, 5'd5, 5'd7, 5'd5, 5'd5};
        logic [4:0]  t_rs2 [5] = '{5'd0, 5'd5, 5'd1, 5'd7, 5'd0};
        logic        t_u2  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [4:0]  t_rd  [5] = '{5'd5, 5'd7, 5'd5, 5'd5, 5'd10};
        logic [7:0]  t_exp [6] = '{8'h00, 8'h00, {2'b00, 3'd3, 3'd3}, {2'b10, 3'd3, 3'd0},
                                   {2'b00, 3'd3, 3'd4}, {2'b00, 3'd3, 3'd0}};
        logic [31:0] e;
        logic [7:0]  obs;
        do_reset();
        imem_ready = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n <= 5) set_id(t_rs1[n-1], t_rs2[n-1], 1'b1, t_u2[n-1], t_rd[n-1], 1'b1, 1'b0);
            else set_nop();
            exp_q.push_back({24'b0, t_exp[n-1]});
            #1;
            e = exp_q.pop_front();
            obs = {byp1_5, byp2_5, fwd1_5, fwd2_5};
            tests++;
            if ({24'b0, obs} !== e || stall5 !== 1'b0) begin
                fails++; $display("FAIL b2b_fwd cycle %0d: byp/fwd=%b stall=%b want %b/0",
                                  n, obs, stall5, e[7:0]);
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        imem_ready = 1'b1;
        tick();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
        tick();
        set_id(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // dependent add
        ex_br_taken = 1'b1;
        ex_br_target = 32'h100;
        #1;
        tests++;
        if (flush5 !== 1'b1 || stall5 !== 1'b0 || fetch_fire5 !== 1'b0) begin
            fails++; $display("FAIL flush_comb: flush=%b stall=%b ff=%b want 1/0/0", flush5, stall5, fetch_fire5);
        end
        tick();
        ex_br_taken = 1'b0;
        set_nop();
        #1;
        tests++;
        if (pc5 !== 32'h100 || sv5 !== 5'b01001) begin
            fails++; $display("FAIL flush_redirect: pc=%h sv=%b want 100/01001", pc5, sv5);
        end
        tick();
        tests++;
        if (pc5 !== 32'h104 || sv5 !== 5'b10011) begin
            fails++; $display("FAIL flush_resume: pc=%h sv=%b want 104/10011", pc5, sv5);
        end
    endtask

    task automatic test_deep_stall();
        int n;
        do_reset();
        imem_ready = 1'b1;
        tick();
        set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);   // lw x3
        tick();
        set_id(5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);   // add x4,x3,x3
        #1;
        n = 0;
        while (stall7 === 1'b1 && n < 10) begin
            n++;
            tick();
        end
        tests++;
        if (n != 3 || pc7 !== 32'h88 || fetch_fire7 !== 1'b1) begin
            fails++; $display("FAIL deep_stall: cycles=%0d pc=%h ff=%b want 3/88/1", n, pc7, fetch_fire7);
        end
        tick();
        set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
        #1;
        tests++;
        if (fwd1_7 !== 3'd6 || fwd2_7 !== 3'd6) begin
            fails++; $display("FAIL deep_fwd: fwd1=%0d fwd2=%0d want 6/6", fwd1_7, fwd2_7);
        end
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);   // add x0,x0,x0
        #1;
        tests++;
        if (stall7 !== 1'b0) begin
            fails++; $display("FAIL x0_nostall: got %b want 0", stall7);
        end
        tick();
        set_id(5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);   // add x9,x0,x0
        tick();
        set_nop();
        #1;
        tests++;
        if (fwd1_7 !== 3'd0 || fwd2_7 !== 3'd0) begin
            fails++; $display("FAIL x0_nofwd: fwd1=%0d fwd2=%0d want 0/0", fwd1_7, fwd2_7);
        end
    endtask

    task automatic test_imem_gap();
        logic [31:0] e_pc, e_ret;
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            imem_ready = !(n >= 5 && n <= 7);
            if (n <= 4)      exp_q.push_back(32'(4 * n));
            else if (n <= 7) exp_q.push_back(32'h10);
            else             exp_q.push_back(32'(16 + 4 * (n - 7)));
            exp_q.push_back({31'b0, ((n >= 4 && n <= 7) || n >= 11)});
            tick();
            e_pc  = exp_q.pop_front();
            e_ret = exp_q.pop_front();
            tests++;
            if (pc5 !== e_pc || retire5 !== e_ret[0]) begin
                fails++; $display("FAIL imem_gap cycle %0d: pc=%h retire=%b want %h/%b",
                                  n, pc5, retire5, e_pc, e_ret[0]);
            end
        end
        tests++;
        if (count5 !== 32'd5) begin
            fails++; $display("FAIL imem_count: got %0d want 5", count5);
        end
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        tests++;
        if (pc5 !== 32'h0 || pc7 !== 32'h80 || sv5 !== 5'b0 || sv7 !== 7'b0 ||
            count5 !== 32'd0 || retire5 !== 1'b0) begin
            fails++; $display("FAIL midrun_reset: pc=%h/%h sv=%b/%b cnt=%0d want 0/80/0/0/0",
                              pc5, pc7, sv5, sv7, count5);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; ex_br_taken = 1'b0; ex_br_target = '0;
        set_nop();
        test_reset();
        test_sequential();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_deep_stall();
        test_imem_gap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
